// File: rtl/token_multiplier_pkg.sv
// Shared constants and the parameter legality check for the token multiplier.
package token_mult_pkg;

    localparam int DEFAULT_CNT_W       = 10;
    localparam int DEFAULT_MULT_W      = 3;
    localparam int DEFAULT_MAX_PENDING = 800;

    // The largest single-token copy count must fit under the budget, and the
    // budget must itself fit in the pending counter.
    function automatic bit params_legal(input int cnt_w, input int mult_w, input int max_pending);
        int max_mult;
        int max_cnt;
        max_mult = (1 << mult_w) - 1;
        max_cnt  = (1 << cnt_w) - 1;
        return (cnt_w > 0) && (mult_w > 0) && (cnt_w >= mult_w)
               && (max_mult <= max_pending) && (max_pending <= max_cnt);
    endfunction

endpackage

// File: rtl/token_multiplier_if.sv
// Token stream bundle between a serial token source/consumer pair and the multiplier.
interface token_multiplier_if
    import token_mult_pkg::*;
#(
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int MULT_W = DEFAULT_MULT_W
) ();

    logic              a;
    logic [MULT_W-1:0] mult;
    logic              out_ready;
    logic              b;
    logic [CNT_W-1:0]  pending;
    logic              overflow;

    modport master (
        output a,
        output mult,
        output out_ready,
        input  b,
        input  pending,
        input  overflow
    );

    modport slave (
        input  a,
        input  mult,
        input  out_ready,
        output b,
        output pending,
        output overflow
    );

endinterface

// File: rtl/token_multiplier_credit_counter.sv
// Pending-copy arithmetic: adds new copies, subtracts an emitted copy, or clears.
// Works in CNT_W+1 bits so an oversubscribed total is visible instead of wrapping.
module token_credit_counter
    import token_mult_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int MULT_W      = DEFAULT_MULT_W,
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING
) (
    input  logic [CNT_W-1:0]  pending,
    input  logic [MULT_W-1:0] add,
    input  logic              dec,
    input  logic              clr,
    output logic [CNT_W:0]    total,
    output logic [CNT_W-1:0]  next_pending,
    output logic              over
);

    localparam logic [CNT_W:0] MAX_P = (CNT_W+1)'(MAX_PENDING);
    localparam logic [CNT_W:0] ONE   = (CNT_W+1)'(1);

    // Sum owed and arriving copies, then pick clear, emit-one or hold.
    always_comb begin
        total        = (CNT_W+1)'(pending) + (CNT_W+1)'(add);
        over         = (total > MAX_P);
        next_pending = CNT_W'(total);
        if (clr) begin
            next_pending = '0;
        end else if (dec) begin
            next_pending = CNT_W'(total - ONE);
        end
    end

endmodule

// File: rtl/token_multiplier.sv
// Serial token multiplier: each input token becomes mult output tokens, one per
// ready cycle, with a sticky overflow once the owed copies exceed MAX_PENDING.
module token_multiplier
    import token_mult_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int MULT_W      = DEFAULT_MULT_W,
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING
) (
    input logic               clk,
    input logic               rst,
    token_multiplier_if.slave bus
);

    generate
        if (!params_legal(CNT_W, MULT_W, MAX_PENDING)) begin : g_bad_params
            $fatal(1, "token_multiplier: illegal CNT_W/MULT_W/MAX_PENDING combination");
        end
    endgenerate

    logic [MULT_W-1:0] add;
    logic [CNT_W:0]    total;
    logic [CNT_W-1:0]  next_pending;
    logic              over;
    logic              clr;
    logic              dec;
    logic [CNT_W-1:0]  pending_q;
    logic              b_q;
    logic              overflow_q;

    // Once overflowed (or overflowing now) nothing is owed; otherwise emit when the consumer is ready.
    always_comb begin
        add = bus.a ? bus.mult : '0;
        clr = overflow_q || over;
        dec = bus.out_ready && (total != '0) && !clr;
    end

    token_credit_counter #(
        .CNT_W       (CNT_W),
        .MULT_W      (MULT_W),
        .MAX_PENDING (MAX_PENDING)
    ) u_counter (
        .pending      (pending_q),
        .add          (add),
        .dec          (dec),
        .clr          (clr),
        .total        (total),
        .next_pending (next_pending),
        .over         (over)
    );

    // Output token, owed-copy count and sticky overflow, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            b_q        <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= next_pending;
            b_q        <= dec;
            overflow_q <= overflow_q || over;
        end
    end

    assign bus.b        = b_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_token_multiplier.sv
// Directed bench for token_multiplier: replication, stall, drop, overflow and reset cases.
module tb_token_multiplier;
    import token_mult_pkg::*;

    localparam int CNT_W       = 10;
    localparam int MULT_W      = 3;
    localparam int MAX_PENDING = 800;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    token_multiplier_if #(.CNT_W(CNT_W), .MULT_W(MULT_W)) bus ();

    token_multiplier #(
        .CNT_W       (CNT_W),
        .MULT_W      (MULT_W),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic a, input logic [MULT_W-1:0] m, input logic rdy);
        rst           = r;
        bus.a         = a;
        bus.mult      = m;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Stimulus sequence; every expected value below is hand-derived.
    initial begin
        logic [25:0] a_vec;
        logic [26:0] b_vec;
        int          e2b[6];
        int          e2p[6];
        int          e3b[4];
        int          e3p[4];

        a_vec = 26'b10010011000110100001100100;
        b_vec = 27'b011011011110111111001111110;
        e2b   = '{1, 1, 1, 1, 1, 0};
        e2p   = '{4, 3, 2, 1, 0, 0};
        e3b   = '{1, 1, 1, 0};
        e3p   = '{2, 1, 0, 0};

        rst           = 1'b1;
        bus.a         = 1'b0;
        bus.mult      = '0;
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("reset_b", bus.b, 0);
        checkOutput("reset_pending", bus.pending, 0);
        checkOutput("reset_overflow", bus.overflow, 0);

        $display("[TB] doubling pattern, mult=2");
        for (int i = 0; i < 26; i++) begin
            applyStimulus(1'b0, a_vec[25-i], 3'd2, 1'b1);
            checkOutput($sformatf("t1_b[%0d]", i), bus.b, b_vec[25-i]);
            checkOutput($sformatf("t1_pending_le2[%0d]", i), bus.pending <= 2, 1);
        end
        checkOutput("t1_pending_end", bus.pending, 0);

        $display("[TB] single pulse, mult=5");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, i == 0, 3'd5, 1'b1);
            checkOutput($sformatf("t2_b[%0d]", i), bus.b, e2b[i]);
            checkOutput($sformatf("t2_pending[%0d]", i), bus.pending, e2p[i]);
        end

        $display("[TB] stalled consumer, mult=3");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, i == 0, 3'd3, 1'b0);
            checkOutput($sformatf("t3_stall_b[%0d]", i), bus.b, 0);
            checkOutput($sformatf("t3_stall_pending[%0d]", i), bus.pending, 3);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd7, 1'b1);
            checkOutput($sformatf("t3_rel_b[%0d]", i), bus.b, e3b[i]);
            checkOutput($sformatf("t3_rel_pending[%0d]", i), bus.pending, e3p[i]);
        end

        $display("[TB] mult=0 drops tokens");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, (i % 2) == 0, 3'd0, i < 4);
            checkOutput($sformatf("t4_b[%0d]", i), bus.b, 0);
            checkOutput($sformatf("t4_pending[%0d]", i), bus.pending, 0);
        end

        $display("[TB] overflow with mult=7 continuous");
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 133; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd7, 1'b1);
            checkOutput($sformatf("t5_pending[%0d]", i), bus.pending, 6 * (i + 1));
        end
        checkOutput("t5_b_before", bus.b, 1);
        checkOutput("t5_overflow_before", bus.overflow, 0);
        applyStimulus(1'b0, 1'b1, 3'd7, 1'b1);
        checkOutput("t5_overflow_set", bus.overflow, 1);
        checkOutput("t5_b_after", bus.b, 0);
        checkOutput("t5_pending_after", bus.pending, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, i >= 5, 3'd1, 1'b1);
            checkOutput($sformatf("t5_sticky_ovf[%0d]", i), bus.overflow, 1);
            checkOutput($sformatf("t5_sticky_b[%0d]", i), bus.b, 0);
            checkOutput($sformatf("t5_sticky_pending[%0d]", i), bus.pending, 0);
        end

        $display("[TB] exact budget boundary");
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("t6_reset_overflow", bus.overflow, 0);
        for (int i = 0; i < 133; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd7, 1'b1);
        end
        checkOutput("t6_pending_798", bus.pending, 798);
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b0);
        checkOutput("t6_pending_800", bus.pending, 800);
        checkOutput("t6_no_overflow_800", bus.overflow, 0);
        checkOutput("t6_b_stalled", bus.b, 0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1);
        checkOutput("t6_b_emit", bus.b, 1);
        checkOutput("t6_pending_799", bus.pending, 799);
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b0);
        checkOutput("t6_overflow_801", bus.overflow, 1);
        checkOutput("t6_pending_cleared", bus.pending, 0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0);
        checkOutput("t7_pending_10", bus.pending, 10);
        applyStimulus(1'b1, 1'b1, 3'd7, 1'b1);
        checkOutput("t7_rst_pending", bus.pending, 0);
        checkOutput("t7_rst_b", bus.b, 0);
        checkOutput("t7_rst_overflow", bus.overflow, 0);
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b1);
        checkOutput("t7_first_b", bus.b, 1);
        checkOutput("t7_first_pending", bus.pending, 0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1);
        checkOutput("t7_idle_b", bus.b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
